// File: rtl/step_counter_pkg.sv
// Shared constants for the step_counter slice.
// Direction and overflow encodings plus default widths.
package step_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/step_counter_if.sv
// Control and status bundle of the step counter.
// The master drives controls; the slave (counter) returns status.
interface step_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);

    logic                  ena;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  dir;
    logic [WIDTH-1:0]      step;
    logic                  sat;
    logic [PRESCALE_W-1:0] div;
    logic [WIDTH-1:0]      cmp_val;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  match;

    modport master (
        output ena, load, load_val, dir, step, sat, div, cmp_val,
        input  count, tc, match
    );

    modport slave (
        input  ena, load, load_val, dir, step, sat, div, cmp_val,
        output count, tc, match
    );

endinterface

// File: rtl/tick_prescaler.sv
// Clock-enable divider: one tick every div+1 enabled cycles.
// A clear restarts the phase and suppresses the tick.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  wrap;

    // >= keeps the period bounded when div is lowered mid-run
    assign wrap = (pcnt >= div);
    assign tick = ena & ~clr & wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (ena) begin
            if (wrap) pcnt <= '0;
            else      pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_counter.sv
// Loadable up/down counter with programmable step, wrap/saturate,
// prescaled tick, terminal-count pulse and compare-match flag.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    step_counter_if.slave bus
);

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             match_q;
    logic [WIDTH:0]   sum;
    logic             oor;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (bus.ena),
        .clr  (bus.load),
        .div  (bus.div),
        .tick (tick)
    );

    // Bit WIDTH is the carry (up) or the borrow (down)
    always_comb begin
        if (bus.dir == DIR_DOWN)
            sum = {1'b0, count_q} - {1'b0, bus.step};
        else
            sum = {1'b0, count_q} + {1'b0, bus.step};
        oor = sum[WIDTH];
    end

    // tick is gated by load, so the two arms never overlap
    always_comb begin
        count_next = count_q;
        tc_next    = 1'b0;
        unique case (1'b1)
            bus.load: begin
                count_next = bus.load_val;
            end
            tick: begin
                count_next = sum[WIDTH-1:0];
                if (oor) begin
                    tc_next = 1'b1;
                    if (bus.sat == MODE_SAT)
                        count_next = (bus.dir == DIR_DOWN) ? '0 : '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_next;
            tc_q    <= tc_next;
            match_q <= (count_next == bus.cmp_val);
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.match = match_q;

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed vector table,
// hand sequences for reset/prescaler, and random vs. a reference model.
module tb_step_counter;

    logic clk;
    logic rst_n;

    step_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

    step_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state (plain integers)
    int m_count;
    int m_phase;
    int m_tc;
    int m_match;

    typedef struct {
        logic       load;
        logic [7:0] load_val;
        logic       dir;
        logic [7:0] step;
        logic       sat;
        logic [7:0] cmp_val;
        logic [7:0] exp_count;
        logic       exp_tc;
        logic       exp_match;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic ld, logic [7:0] lv, logic d,
                                logic [7:0] st, logic s, logic [7:0] cv,
                                logic [7:0] ec, logic et, logic em);
        vec_t v;
        v.load = ld; v.load_val = lv; v.dir = d; v.step = st;
        v.sat = s; v.cmp_val = cv;
        v.exp_count = ec; v.exp_tc = et; v.exp_match = em;
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0; m_phase = 0; m_tc = 0; m_match = 0;
    endtask

    // Advance the model by one rising edge using the current inputs
    task automatic model_edge();
        int s;
        if (bus.load) begin
            m_count = int'(bus.load_val);
            m_phase = 0;
            m_tc    = 0;
        end else if (bus.ena) begin
            m_tc = 0;
            if (m_phase >= int'(bus.div)) begin
                m_phase = 0;
                if (bus.dir) s = m_count - int'(bus.step);
                else         s = m_count + int'(bus.step);
                if (s < 0 || s > 255) begin
                    m_tc = 1;
                    if (bus.sat) m_count = bus.dir ? 0 : 255;
                    else         m_count = (s + 256) % 256;
                end else begin
                    m_count = s;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else begin
            m_tc = 0;
        end
        m_match = (m_count == int'(bus.cmp_val)) ? 1 : 0;
    endtask

    task automatic check(string name, logic [7:0] ec, logic et, logic em);
        vectors++;
        if (bus.count !== ec || bus.tc !== et || bus.match !== em) begin
            errors++;
            $display("FAIL %s: got count=%02h tc=%b match=%b, want count=%02h tc=%b match=%b",
                     name, bus.count, bus.tc, bus.match, ec, et, em);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.ena = 1'b1; bus.load = 1'b0; bus.load_val = 8'h00;
        bus.dir = 1'b0; bus.step = 8'h01; bus.sat = 1'b0;
        bus.div = 4'd0; bus.cmp_val = 8'h00;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset_state", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // up wrap / down sat / compare / load-beats-tick / extra bounds
        tbl.push_back(mk(1, 8'hFE, 0, 8'd3, 0, 8'h00, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd3, 0, 8'h00, 8'h01, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd3, 0, 8'h00, 8'h04, 0, 0));
        tbl.push_back(mk(1, 8'h05, 1, 8'd4, 1, 8'h00, 8'h05, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 8'd4, 1, 8'h00, 8'h01, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 8'd4, 1, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 8'd4, 1, 8'h00, 8'h00, 1, 1));
        tbl.push_back(mk(1, 8'h0E, 0, 8'd1, 0, 8'h10, 8'h0E, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd1, 0, 8'h10, 8'h0F, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd1, 0, 8'h10, 8'h10, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 8'd1, 0, 8'h10, 8'h11, 0, 0));
        tbl.push_back(mk(1, 8'h80, 0, 8'd1, 0, 8'h10, 8'h80, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd1, 0, 8'h10, 8'h81, 0, 0));
        tbl.push_back(mk(1, 8'hFD, 0, 8'd2, 1, 8'h00, 8'hFD, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd2, 1, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd2, 1, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 8'd0, 1, 8'hFF, 8'hFF, 0, 1));
        tbl.push_back(mk(1, 8'h02, 1, 8'd3, 0, 8'h00, 8'h02, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 8'd3, 0, 8'h00, 8'hFF, 1, 0));

        foreach (tbl[i]) begin
            bus.load = tbl[i].load; bus.load_val = tbl[i].load_val;
            bus.dir = tbl[i].dir; bus.step = tbl[i].step;
            bus.sat = tbl[i].sat; bus.cmp_val = tbl[i].cmp_val;
            edge_step();
            check($sformatf("table[%0d]", i), tbl[i].exp_count,
                  tbl[i].exp_tc, tbl[i].exp_match);
        end

        // Async reset mid-run at 0x37 with match high
        set_idle();
        bus.load = 1'b1; bus.load_val = 8'h37; bus.cmp_val = 8'h37;
        bus.step = 8'h00;
        edge_step();
        check("pre_reset", 8'h37, 1'b0, 1'b1);
        bus.load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", 8'h00, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;

        // Prescaler div=2 with a 5-cycle enable gap
        set_idle();
        bus.div = 4'd2; bus.cmp_val = 8'hAA;
        begin
            logic [7:0] pre_exp [6];
            pre_exp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
            for (int k = 0; k < 4; k++) begin
                edge_step();
                check($sformatf("presc[%0d]", k), pre_exp[k], 1'b0, 1'b0);
            end
            bus.ena = 1'b0;
            for (int k = 0; k < 5; k++) begin
                edge_step();
                check($sformatf("hold[%0d]", k), 8'd1, 1'b0, 1'b0);
            end
            bus.ena = 1'b1;
            for (int k = 4; k < 6; k++) begin
                edge_step();
                check($sformatf("presc[%0d]", k), pre_exp[k], 1'b0, 1'b0);
            end
        end

        // Randomised run against the reference model
        for (int n = 0; n < 600; n++) begin
            bus.load     = ($urandom_range(0, 15) == 0);
            bus.load_val = 8'($urandom);
            bus.ena      = ($urandom_range(0, 7) != 0);
            bus.dir      = 1'($urandom);
            bus.step     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 80));
            bus.sat      = 1'($urandom);
            bus.div      = 4'($urandom_range(0, 3));
            bus.cmp_val  = ($urandom_range(0, 3) == 0) ? 8'(m_count) : 8'($urandom);
            edge_step();
            check($sformatf("rand[%0d]", n), 8'(m_count), m_tc[0], m_match[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
